// File: rtl/biriscv_alu_issue_arb_if.sv
// rtl/biriscv_alu_issue_arb_if.sv - request, ALU-drive and writeback signals of the shared-ALU arbiter
interface biriscv_alu_issue_arb_if;
    logic        hold_i;
    logic        flush_i;

    logic        req0_valid_i;
    logic        req0_ready_o;
    logic [3:0]  req0_op_i;
    logic [31:0] req0_a_i;
    logic [31:0] req0_b_i;
    logic [4:0]  req0_rd_i;

    logic        req1_valid_i;
    logic        req1_ready_o;
    logic [3:0]  req1_op_i;
    logic [31:0] req1_a_i;
    logic [31:0] req1_b_i;
    logic [4:0]  req1_rd_i;

    logic        alu_valid_o;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic        alu_valid_i;
    logic [31:0] alu_p_i;

    logic        wb0_valid_o;
    logic [4:0]  wb0_rd_o;
    logic [31:0] wb0_value_o;
    logic        wb1_valid_o;
    logic [4:0]  wb1_rd_o;
    logic [31:0] wb1_value_o;

    logic [31:0] busy_rd_o;
    logic        err_o;

    modport slave (
        input  hold_i, flush_i,
        input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i, req0_rd_i,
        output req0_ready_o,
        input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i, req1_rd_i,
        output req1_ready_o,
        output alu_valid_o, alu_op_o, alu_a_o, alu_b_o,
        input  alu_valid_i, alu_p_i,
        output wb0_valid_o, wb0_rd_o, wb0_value_o,
        output wb1_valid_o, wb1_rd_o, wb1_value_o,
        output busy_rd_o, err_o
    );

    modport master (
        output hold_i, flush_i,
        output req0_valid_i, req0_op_i, req0_a_i, req0_b_i, req0_rd_i,
        input  req0_ready_o,
        output req1_valid_i, req1_op_i, req1_a_i, req1_b_i, req1_rd_i,
        input  req1_ready_o,
        input  alu_valid_o, alu_op_o, alu_a_o, alu_b_o,
        output alu_valid_i, alu_p_i,
        input  wb0_valid_o, wb0_rd_o, wb0_value_o,
        input  wb1_valid_o, wb1_rd_o, wb1_value_o,
        input  busy_rd_o, err_o
    );
endinterface

// File: rtl/biriscv_alu_issue_arb.sv
// rtl/biriscv_alu_issue_arb.sv - round-robin sharing of one pipelined ALU between two issue pipes
module biriscv_alu_issue_arb #(
    parameter int ALU_LATENCY = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    biriscv_alu_issue_arb_if.slave    bus
);
    localparam int LAST = ALU_LATENCY - 1;

    logic                          last_grant_q, last_grant_d;
    logic [ALU_LATENCY-1:0]        tag_valid_q, tag_valid_d;
    logic [ALU_LATENCY-1:0]        tag_src_q, tag_src_d;
    logic [ALU_LATENCY-1:0][4:0]   tag_rd_q, tag_rd_d;
    logic [2:0]                    mask_cnt_q, mask_cnt_d;
    logic                          err_q, err_d;

    logic        grant;
    logic        grant_pipe;
    logic [4:0]  grant_rd;
    logic        last_valid;
    logic [31:0] busy;

    // When both pipes contend, the one that did not win most recently gets the ALU.
    always_comb begin
        grant      = 1'b0;
        grant_pipe = 1'b0;
        if (!bus.hold_i && !bus.flush_i) begin
            if (bus.req0_valid_i && bus.req1_valid_i) begin
                grant      = 1'b1;
                grant_pipe = ~last_grant_q;
            end else if (bus.req0_valid_i) begin
                grant      = 1'b1;
                grant_pipe = 1'b0;
            end else if (bus.req1_valid_i) begin
                grant      = 1'b1;
                grant_pipe = 1'b1;
            end
        end
        grant_rd     = grant ? (grant_pipe ? bus.req1_rd_i : bus.req0_rd_i) : 5'd0;
        last_grant_d = grant ? grant_pipe : last_grant_q;
    end

    assign bus.req0_ready_o = grant & ~grant_pipe;
    assign bus.req1_ready_o = grant &  grant_pipe;

    assign bus.alu_valid_o = grant;
    assign bus.alu_op_o    = !grant ? 4'd0  : (grant_pipe ? bus.req1_op_i : bus.req0_op_i);
    assign bus.alu_a_o     = !grant ? 32'd0 : (grant_pipe ? bus.req1_a_i  : bus.req0_a_i);
    assign bus.alu_b_o     = !grant ? 32'd0 : (grant_pipe ? bus.req1_b_i  : bus.req0_b_i);

    // The tag pipe shadows the free-running ALU, so it shifts regardless of hold_i.
    always_comb begin
        tag_valid_d    = tag_valid_q;
        tag_src_d      = tag_src_q;
        tag_rd_d       = tag_rd_q;
        tag_valid_d[0] = grant;
        tag_src_d[0]   = grant_pipe;
        tag_rd_d[0]    = grant_rd;
        for (int i = 1; i < ALU_LATENCY; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_src_d[i]   = tag_src_q[i-1];
            tag_rd_d[i]    = tag_rd_q[i-1];
        end
        if (bus.flush_i) begin
            tag_valid_d = '0;
        end
    end

    assign last_valid = tag_valid_q[LAST] & ~bus.flush_i;

    assign bus.wb0_valid_o = last_valid & ~tag_src_q[LAST];
    assign bus.wb1_valid_o = last_valid &  tag_src_q[LAST];
    assign bus.wb0_rd_o    = bus.wb0_valid_o ? tag_rd_q[LAST] : 5'd0;
    assign bus.wb1_rd_o    = bus.wb1_valid_o ? tag_rd_q[LAST] : 5'd0;
    assign bus.wb0_value_o = bus.wb0_valid_o ? bus.alu_p_i : 32'd0;
    assign bus.wb1_value_o = bus.wb1_valid_o ? bus.alu_p_i : 32'd0;

    // Results of ops killed by a flush keep emerging from the ALU for a while; the
    // mask window hides them from the tag/valid consistency check.
    always_comb begin
        if (bus.flush_i) begin
            mask_cnt_d = 3'(ALU_LATENCY);
        end else if (mask_cnt_q != 3'd0) begin
            mask_cnt_d = mask_cnt_q - 3'd1;
        end else begin
            mask_cnt_d = mask_cnt_q;
        end
        err_d = err_q;
        if (!bus.flush_i && (mask_cnt_q == 3'd0) && (tag_valid_q[LAST] != bus.alu_valid_i)) begin
            err_d = 1'b1;
        end
    end

    assign bus.err_o = err_q;

    always_comb begin
        busy = 32'd0;
        for (int i = 0; i < ALU_LATENCY; i++) begin
            if (tag_valid_q[i]) begin
                busy = busy | (32'd1 << tag_rd_q[i]);
            end
        end
        if (grant) begin
            busy = busy | (32'd1 << grant_rd);
        end
        busy[0] = 1'b0;
    end

    assign bus.busy_rd_o = busy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= 1'b1;
            tag_valid_q  <= '0;
            tag_src_q    <= '0;
            tag_rd_q     <= '0;
            mask_cnt_q   <= 3'd0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            tag_valid_q  <= tag_valid_d;
            tag_src_q    <= tag_src_d;
            tag_rd_q     <= tag_rd_d;
            mask_cnt_q   <= mask_cnt_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_biriscv_alu_issue_arb.sv
// tb/tb_biriscv_alu_issue_arb.sv - scoreboard bench for the shared-ALU issue arbiter
module tb_biriscv_alu_issue_arb;
    localparam int L = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    biriscv_alu_issue_arb_if bus ();

    biriscv_alu_issue_arb #(.ALU_LATENCY(L)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit ref_last = 1'b1;
    bit consumed0, consumed1;
    bit alu_kill = 1'b0;
    bit exp_err  = 1'b0;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd4:    return a + b;
            4'd6:    return a - b;
            4'd7:    return a & b;
            4'd8:    return a | b;
            4'd9:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    // Stand-in for the fixed-latency ALU; alu_kill drops its valid to provoke a mismatch.
    logic [L-1:0]       mv;
    logic [L-1:0][31:0] mp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv <= '0;
        end else begin
            for (int i = L - 1; i > 0; i--) begin
                mv[i] <= mv[i-1];
                mp[i] <= mp[i-1];
            end
            mv[0] <= bus.alu_valid_o;
            mp[0] <= alu_ref(bus.alu_op_o, bus.alu_a_o, bus.alu_b_o);
        end
    end
    assign bus.alu_valid_i = mv[L-1] & ~alu_kill;
    assign bus.alu_p_i     = mp[L-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
        if (p == 0) begin
            bus.req0_valid_i = 1'b1; bus.req0_op_i = op; bus.req0_a_i = a;
            bus.req0_b_i = b; bus.req0_rd_i = rd;
        end else begin
            bus.req1_valid_i = 1'b1; bus.req1_op_i = op; bus.req1_a_i = a;
            bus.req1_b_i = b; bus.req1_rd_i = rd;
        end
    endtask

    // Stimulus side: checks the grant against the round-robin rules and records expectations.
    task automatic sample();
        bit en, g0, g1;
        exp_t e;
        @(negedge clk);
        en = !bus.hold_i && !bus.flush_i;
        g0 = en && bus.req0_valid_i && (!bus.req1_valid_i || ref_last);
        g1 = en && bus.req1_valid_i && (!bus.req0_valid_i || !ref_last);
        check("req0_ready", bus.req0_ready_o, g0);
        check("req1_ready", bus.req1_ready_o, g1);
        check("alu_valid", bus.alu_valid_o, g0 | g1);
        check("alu_op", bus.alu_op_o, g0 ? bus.req0_op_i : (g1 ? bus.req1_op_i : 4'd0));
        check("alu_a", bus.alu_a_o, g0 ? bus.req0_a_i : (g1 ? bus.req1_a_i : 32'd0));
        check("alu_b", bus.alu_b_o, g0 ? bus.req0_b_i : (g1 ? bus.req1_b_i : 32'd0));
        if (g0) begin
            e.rd = bus.req0_rd_i; e.val = alu_ref(bus.req0_op_i, bus.req0_a_i, bus.req0_b_i); e.due = cyc + L;
            exp_q0.push_back(e);
            consumed0 = 1'b1;
            ref_last  = 1'b0;
        end
        if (g1) begin
            e.rd = bus.req1_rd_i; e.val = alu_ref(bus.req1_op_i, bus.req1_a_i, bus.req1_b_i); e.due = cyc + L;
            exp_q1.push_back(e);
            consumed1 = 1'b1;
            ref_last  = 1'b1;
        end
    endtask

    task automatic step(input bit h, input bit f);
        bus.hold_i  = h;
        bus.flush_i = f;
        sample();
        @(posedge clk);
        #1;
        if (consumed0) begin bus.req0_valid_i = 1'b0; consumed0 = 1'b0; end
        if (consumed1) begin bus.req1_valid_i = 1'b0; consumed1 = 1'b0; end
        bus.hold_i  = 1'b0;
        bus.flush_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        ref_last  = 1'b1;
        consumed0 = 1'b0;
        consumed1 = 1'b0;
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        bus.hold_i  = 1'b0;
        bus.flush_i = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        check("rst_busy", bus.busy_rd_o, 32'd0);
        check("rst_err", bus.err_o, 1'b0);
        check("rst_wb_valid", {bus.wb0_valid_o, bus.wb1_valid_o}, 2'b00);
        check("rst_alu_valid", bus.alu_valid_o, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wb_check(input int p, input logic v, input logic [4:0] rd, input logic [31:0] val);
        exp_t e;
        bit have;
        have = 1'b0;
        if (p == 0 && exp_q0.size() > 0 && exp_q0[0].due == cyc) begin
            e = exp_q0.pop_front(); have = 1'b1;
        end
        if (p == 1 && exp_q1.size() > 0 && exp_q1[0].due == cyc) begin
            e = exp_q1.pop_front(); have = 1'b1;
        end
        check($sformatf("wb%0d_valid", p), v, have);
        if (have) begin
            check($sformatf("wb%0d_rd", p), rd, e.rd);
            check($sformatf("wb%0d_value", p), val, e.val);
        end else begin
            check($sformatf("wb%0d_idle_zero", p), {27'd0, rd} | val, 32'd0);
        end
    endtask

    // Monitor: every result still owed counts as busy until its writeback cycle.
    always begin
        logic [31:0] m;
        @(negedge clk);
        #1;
        if (rst_n) begin
            m = 32'd0;
            foreach (exp_q0[i]) if (exp_q0[i].due >= cyc) m = m | (32'd1 << exp_q0[i].rd);
            foreach (exp_q1[i]) if (exp_q1[i].due >= cyc) m = m | (32'd1 << exp_q1[i].rd);
            m[0] = 1'b0;
            check("busy_rd", bus.busy_rd_o, m);
            check("err", bus.err_o, exp_err);
            if (bus.flush_i) begin
                exp_q0.delete();
                exp_q1.delete();
            end
            wb_check(0, bus.wb0_valid_o, bus.wb0_rd_o, bus.wb0_value_o);
            wb_check(1, bus.wb1_valid_o, bus.wb1_rd_o, bus.wb1_value_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.hold_i = 1'b0; bus.flush_i = 1'b0;
        bus.req0_valid_i = 1'b0; bus.req0_op_i = '0; bus.req0_a_i = '0; bus.req0_b_i = '0; bus.req0_rd_i = '0;
        bus.req1_valid_i = 1'b0; bus.req1_op_i = '0; bus.req1_a_i = '0; bus.req1_b_i = '0; bus.req1_rd_i = '0;
        do_reset();

        // Single ADD with a known result.
        set_req(0, 4'd4, 32'd5, 32'd7, 5'd3);
        step(0, 0);
        repeat (3) step(0, 0);

        // Two contending pipes for four cycles.
        for (int k = 0; k < 4; k++) begin
            if (!bus.req0_valid_i) set_req(0, 4'd6, $urandom, $urandom, 5'd1);
            if (!bus.req1_valid_i) set_req(1, 4'd6, $urandom, $urandom, 5'd2);
            step(0, 0);
        end
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        repeat (3) step(0, 0);

        // Hold blocks a new grant while an older op drains on schedule.
        set_req(0, 4'd9, 32'h0f0f_0f0f, 32'h00ff_00ff, 5'd4);
        step(0, 0);
        set_req(1, 4'd7, 32'hdead_beef, 32'hffff_0000, 5'd5);
        repeat (3) step(1, 0);
        step(0, 0);
        repeat (3) step(0, 0);

        // Flush kills two in-flight ops.
        set_req(0, 4'd4, 32'd100, 32'd1, 5'd6);
        set_req(1, 4'd4, 32'd200, 32'd2, 5'd7);
        step(0, 0);
        step(0, 0);
        step(1, 1);
        repeat (4) step(0, 0);

        // Dropped ALU valid under a live tag raises a sticky error cleared only by reset.
        set_req(0, 4'd8, 32'h1200, 32'h0034, 5'd8);
        step(0, 0);
        step(0, 0);
        alu_kill = 1'b1;
        step(0, 0);
        alu_kill = 1'b0;
        exp_err  = 1'b1;
        repeat (3) step(0, 0);
        do_reset();

        // rd=0 never shows as busy but still writes back.
        set_req(0, 4'd4, 32'd9, 32'd9, 5'd0);
        step(0, 0);
        repeat (3) step(0, 0);

        // Random traffic with holds, flushes and one mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            if (!bus.req0_valid_i && ($urandom_range(0, 2) != 0))
                set_req(0, 4'($urandom_range(4, 9)), $urandom, $urandom, 5'($urandom_range(0, 31)));
            if (!bus.req1_valid_i && ($urandom_range(0, 2) != 0))
                set_req(1, 4'($urandom_range(4, 9)), $urandom, $urandom, 5'($urandom_range(0, 31)));
            if (i == 200) do_reset();
            else step($urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
        end
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        repeat (L + 2) step(0, 0);
        check("drain_empty", exp_q0.size() + exp_q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
